// File: rtl/multicycle_ctrl_seq_if.sv
// Bus bundle between the multicycle sequencer and the core datapath/memory.
// Perf-counter signals exist only when CTRL_PERF_CNT_EN is defined.
interface multicycle_ctrl_seq_if #(
    parameter int INSTR_W = 8
);
    localparam int OFF_W = INSTR_W - 3;

    logic [INSTR_W-1:0] instr;
    logic               zf;
    logic               mem_ready;
    logic               resume;
    logic [2:0]         state;
    logic               pc_we;
    logic               pc_sel;
    logic               pc_jmp_sel;
    logic [OFF_W-1:0]   pc_offset;
    logic               addr_sel;
    logic [OFF_W-1:0]   addr_offset;
    logic               mem_sel;
    logic               mem_we;
    logic [2:0]         alu_opcode;
    logic               alu_we;
    logic               zf_we;
    logic               ir_we;
    logic               a_we;
    logic               a_sel;
    logic               halt;
    logic               bus_err;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]        retired;
    logic [31:0]        stall_cycles;
`endif

    modport master (
        output instr, zf, mem_ready, resume,
        input  state, pc_we, pc_sel, pc_jmp_sel, pc_offset,
        input  addr_sel, addr_offset, mem_sel, mem_we,
        input  alu_opcode, alu_we, zf_we, ir_we, a_we, a_sel,
        input  halt, bus_err
`ifdef CTRL_PERF_CNT_EN
        , input retired, stall_cycles
`endif
    );

    modport slave (
        input  instr, zf, mem_ready, resume,
        output state, pc_we, pc_sel, pc_jmp_sel, pc_offset,
        output addr_sel, addr_offset, mem_sel, mem_we,
        output alu_opcode, alu_we, zf_we, ir_we, a_we, a_sel,
        output halt, bus_err
`ifdef CTRL_PERF_CNT_EN
        , output retired, stall_cycles
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_seq.sv
// Multicycle control sequencer for the accumulator CPU, with memory wait/timeout.
// Optional perf counters (retired, stall_cycles) under macro CTRL_PERF_CNT_EN.
module multicycle_ctrl_seq #(
    parameter int INSTR_W = 8,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input logic clk,
    input logic reset_n,
    multicycle_ctrl_seq_if.slave bus
);
    localparam int OFF_W = INSTR_W - 3;
    localparam logic [TO_W-1:0] L_TMO = TO_W'(TIMEOUT);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_JUMP  = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [TO_W-1:0]  r_cnt;
    logic             r_bus_err;
    logic [2:0]       w_op;
    logic [OFF_W-1:0] w_off;
    logic             w_wait;
    logic             w_tmo;

    assign w_op        = bus.instr[INSTR_W-1 -: 3];
    assign w_off       = bus.instr[OFF_W-1:0];
    assign bus.state   = r_state;
    assign bus.bus_err = r_bus_err;

    // Decode next state and strobes from the state register and live inputs
    always_comb begin
        w_next          = r_state;
        w_wait          = 1'b0;
        w_tmo           = 1'b0;
        bus.pc_we       = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.pc_jmp_sel  = 1'b0;
        bus.pc_offset   = '0;
        bus.addr_sel    = 1'b0;
        bus.addr_offset = '0;
        bus.mem_sel     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.alu_opcode  = 3'b000;
        bus.alu_we      = 1'b0;
        bus.zf_we       = 1'b0;
        bus.ir_we       = 1'b0;
        bus.a_we        = 1'b0;
        bus.a_sel       = 1'b0;
        bus.halt        = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    w_next    = S_DECODE;
                end else begin
                    w_wait = 1'b1;
                    if (r_cnt == L_TMO) begin
                        w_tmo  = 1'b1;
                        w_next = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_LOAD, OP_STORE: w_next = S_MEMORY;
                    OP_HALT:           w_next = S_HALT;
                    default:           w_next = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                case (w_op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        bus.alu_opcode = w_op;
                        bus.alu_we     = 1'b1;
                        bus.zf_we      = 1'b1;
                        w_next         = S_WRITEBACK;
                    end
                    OP_JUMP, OP_JZ: begin
                        bus.pc_jmp_sel = 1'b1;
                        bus.pc_offset  = w_off;
                        bus.pc_we      = (w_op == OP_JUMP) | bus.zf;
                        w_next         = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                bus.addr_sel    = 1'b1;
                bus.mem_sel     = 1'b1;
                bus.addr_offset = w_off;
                bus.mem_we      = (w_op == OP_STORE);
                if (bus.mem_ready) begin
                    w_next = (w_op == OP_LOAD) ? S_WRITEBACK : S_FETCH;
                end else begin
                    w_wait = 1'b1;
                    if (r_cnt == L_TMO) begin
                        w_tmo  = 1'b1;
                        w_next = S_HALT;
                    end
                end
            end
            S_WRITEBACK: begin
                bus.a_we  = 1'b1;
                bus.a_sel = (w_op == OP_LOAD);
                w_next    = S_FETCH;
            end
            S_HALT: begin
                bus.halt = 1'b1;
                if (bus.resume && !r_bus_err) begin
                    w_next = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    // State register, wait counter and sticky bus error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_tmo) begin
                r_bus_err <= 1'b1;
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_retired;
    logic [31:0] r_stall;
    logic        w_retire;

    assign w_retire = (w_next == S_FETCH) &&
                      (r_state == S_EXECUTE ||
                       r_state == S_MEMORY ||
                       r_state == S_WRITEBACK);

    // Count completed instructions and memory stall cycles
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
            if (w_wait) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign bus.retired      = r_retired;
    assign bus.stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Directed testbench for multicycle_ctrl_seq (8-bit and 12-bit instances).
// Perf-counter checks are active only when CTRL_PERF_CNT_EN is defined.
module tb_multicycle_ctrl_seq;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    multicycle_ctrl_seq_if #(.INSTR_W(8))  b8 ();
    multicycle_ctrl_seq_if #(.INSTR_W(12)) b12 ();

    multicycle_ctrl_seq #(.INSTR_W(8), .TIMEOUT(15), .TO_W(4)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b8)
    );

    multicycle_ctrl_seq #(.INSTR_W(12), .TIMEOUT(15), .TO_W(4)) u_dut12 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        b8.mem_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (b8.state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %0d exp 0", b8.state);
        end
        checks++;
        if (b8.bus_err !== 1'b0 || b8.halt !== 1'b0 || b8.ir_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got err=%b halt=%b ir_we=%b exp 0 0 0",
                     b8.bus_err, b8.halt, b8.ir_we);
        end
    endtask

    task automatic test_alu();
        for (int i = 0; i < 3; i++) begin
            logic [2:0] op;
            op = 3'(i);
            b8.instr = {op, 5'h00};
            b8.mem_ready = 1'b1;
            #1;
            checks++;
            if (b8.ir_we !== 1'b1 || b8.pc_we !== 1'b1 || b8.pc_sel !== 1'b0) begin
                errors++;
                $display("FAIL alu_fetch got ir=%b pc=%b sel=%b exp 1 1 0",
                         b8.ir_we, b8.pc_we, b8.pc_sel);
            end
            tick();
            checks++;
            if (b8.state !== 3'd1 || b8.alu_we !== 1'b0 || b8.ir_we !== 1'b0) begin
                errors++;
                $display("FAIL alu_decode got st=%0d alu_we=%b ir=%b exp 1 0 0",
                         b8.state, b8.alu_we, b8.ir_we);
            end
            tick();
            checks++;
            if (b8.state !== 3'd2 || b8.alu_we !== 1'b1 || b8.zf_we !== 1'b1 ||
                b8.alu_opcode !== op) begin
                errors++;
                $display("FAIL alu_exec got st=%0d we=%b zf=%b op=%0d exp 2 1 1 %0d",
                         b8.state, b8.alu_we, b8.zf_we, b8.alu_opcode, op);
            end
            tick();
            checks++;
            if (b8.state !== 3'd4 || b8.a_we !== 1'b1 || b8.a_sel !== 1'b0) begin
                errors++;
                $display("FAIL alu_wb got st=%0d a_we=%b a_sel=%b exp 4 1 0",
                         b8.state, b8.a_we, b8.a_sel);
            end
            tick();
            checks++;
            if (b8.state !== 3'd0) begin
                errors++;
                $display("FAIL alu_done got %0d exp 0", b8.state);
            end
        end
    endtask

    task automatic test_load();
        b8.instr = 8'h6A;
        b8.mem_ready = 1'b1;
        tick();
        tick();
        b8.mem_ready = 1'b0;
        #1;
        checks++;
        if (b8.state !== 3'd3 || b8.addr_offset !== 5'h0A || b8.mem_sel !== 1'b1 ||
            b8.mem_we !== 1'b0 || b8.addr_sel !== 1'b1) begin
            errors++;
            $display("FAIL load_mem got st=%0d off=%0h sel=%b we=%b as=%b exp 3 a 1 0 1",
                     b8.state, b8.addr_offset, b8.mem_sel, b8.mem_we, b8.addr_sel);
        end
        tick();
        tick();
        tick();
        b8.mem_ready = 1'b1;
        #1;
        checks++;
        if (b8.state !== 3'd3 || b8.addr_offset !== 5'h0A) begin
            errors++;
            $display("FAIL load_wait got st=%0d off=%0h exp 3 a", b8.state, b8.addr_offset);
        end
        tick();
        checks++;
        if (b8.state !== 3'd4 || b8.a_we !== 1'b1 || b8.a_sel !== 1'b1) begin
            errors++;
            $display("FAIL load_wb got st=%0d a_we=%b a_sel=%b exp 4 1 1",
                     b8.state, b8.a_we, b8.a_sel);
        end
        tick();
    endtask

    task automatic test_store();
        b8.instr = 8'h85;
        b8.mem_ready = 1'b1;
        tick();
        tick();
        b8.mem_ready = 1'b0;
        #1;
        checks++;
        if (b8.state !== 3'd3 || b8.mem_we !== 1'b1 || b8.addr_offset !== 5'h05) begin
            errors++;
            $display("FAIL store_mem got st=%0d we=%b off=%0h exp 3 1 5",
                     b8.state, b8.mem_we, b8.addr_offset);
        end
        tick();
        b8.mem_ready = 1'b1;
        #1;
        checks++;
        if (b8.state !== 3'd3 || b8.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL store_ready got st=%0d we=%b exp 3 1", b8.state, b8.mem_we);
        end
        tick();
        checks++;
        if (b8.state !== 3'd0) begin
            errors++;
            $display("FAIL store_done got %0d exp 0", b8.state);
        end
    endtask

    task automatic test_jz();
        b8.instr = 8'hC3;
        b8.zf = 1'b0;
        b8.mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (b8.state !== 3'd2 || b8.pc_we !== 1'b0 || b8.pc_jmp_sel !== 1'b1 ||
            b8.pc_offset !== 5'h03) begin
            errors++;
            $display("FAIL jz_nottaken got st=%0d we=%b js=%b off=%0h exp 2 0 1 3",
                     b8.state, b8.pc_we, b8.pc_jmp_sel, b8.pc_offset);
        end
        b8.zf = 1'b1;
        #1;
        checks++;
        if (b8.pc_we !== 1'b1 || b8.pc_offset !== 5'h03) begin
            errors++;
            $display("FAIL jz_taken got we=%b off=%0h exp 1 3", b8.pc_we, b8.pc_offset);
        end
        tick();
        b8.zf = 1'b0;
        checks++;
        if (b8.state !== 3'd0) begin
            errors++;
            $display("FAIL jz_done got %0d exp 0", b8.state);
        end
    endtask

    task automatic test_timeout();
        b8.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (b8.state !== 3'd0 || b8.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_before got st=%0d err=%b exp 0 0", b8.state, b8.bus_err);
        end
        tick();
        checks++;
        if (b8.state !== 3'd5 || b8.bus_err !== 1'b1 || b8.halt !== 1'b1) begin
            errors++;
            $display("FAIL tmo_halt got st=%0d err=%b halt=%b exp 5 1 1",
                     b8.state, b8.bus_err, b8.halt);
        end
        b8.resume = 1'b1;
        tick();
        checks++;
        if (b8.state !== 3'd5 || b8.bus_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_resume got st=%0d err=%b exp 5 1", b8.state, b8.bus_err);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        b8.resume = 1'b0;
        #1;
        checks++;
        if (b8.state !== 3'd0 || b8.bus_err !== 1'b0 || b8.halt !== 1'b0) begin
            errors++;
            $display("FAIL tmo_reset got st=%0d err=%b halt=%b exp 0 0 0",
                     b8.state, b8.bus_err, b8.halt);
        end
    endtask

    task automatic test_timeout_edge();
        b8.instr = 8'h00;
        b8.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        b8.mem_ready = 1'b1;
        #1;
        checks++;
        if (b8.ir_we !== 1'b1) begin
            errors++;
            $display("FAIL edge_ready got ir_we=%b exp 1", b8.ir_we);
        end
        tick();
        checks++;
        if (b8.state !== 3'd1 || b8.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL edge_decode got st=%0d err=%b exp 1 0", b8.state, b8.bus_err);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_halt();
        b8.instr = 8'hE0;
        b8.mem_ready = 1'b1;
        b8.resume = 1'b0;
        tick();
        tick();
        checks++;
        if (b8.state !== 3'd5 || b8.halt !== 1'b1 || b8.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter got st=%0d halt=%b err=%b exp 5 1 0",
                     b8.state, b8.halt, b8.bus_err);
        end
        tick();
        checks++;
        if (b8.state !== 3'd5) begin
            errors++;
            $display("FAIL halt_hold got %0d exp 5", b8.state);
        end
        b8.resume = 1'b1;
        tick();
        b8.resume = 1'b0;
        checks++;
        if (b8.state !== 3'd0 || b8.halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_resume got st=%0d halt=%b exp 0 0", b8.state, b8.halt);
        end
    endtask

    task automatic test_reset_mid_wait();
        b8.instr = 8'h6A;
        b8.mem_ready = 1'b1;
        tick();
        tick();
        b8.mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (b8.state !== 3'd0) begin
            errors++;
            $display("FAIL midwait_reset got %0d exp 0", b8.state);
        end
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (b8.state !== 3'd0 || b8.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL midwait_cnt got st=%0d err=%b exp 0 0", b8.state, b8.bus_err);
        end
    endtask

    task automatic test_jump12();
        reset_n = 1'b0;
        b12.instr = 12'hA7F;
        b12.mem_ready = 1'b1;
        b8.mem_ready = 1'b1;
        b8.instr = 8'h00;
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (b12.state !== 3'd0 || b12.ir_we !== 1'b1) begin
            errors++;
            $display("FAIL j12_fetch got st=%0d ir=%b exp 0 1", b12.state, b12.ir_we);
        end
        tick();
        tick();
        checks++;
        if (b12.state !== 3'd2 || b12.pc_offset !== 9'h07F ||
            b12.pc_jmp_sel !== 1'b1 || b12.pc_we !== 1'b1) begin
            errors++;
            $display("FAIL j12_exec got st=%0d off=%0h js=%b we=%b exp 2 7f 1 1",
                     b12.state, b12.pc_offset, b12.pc_jmp_sel, b12.pc_we);
        end
        tick();
        checks++;
        if (b12.state !== 3'd0) begin
            errors++;
            $display("FAIL j12_done got %0d exp 0", b12.state);
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (b12.retired !== 32'd1 || b12.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL j12_perf got ret=%0d stall=%0d exp 1 0",
                     b12.retired, b12.stall_cycles);
        end
        b12.mem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (b12.stall_cycles !== 32'd2 || b12.retired !== 32'd1) begin
            errors++;
            $display("FAIL j12_stall got stall=%0d ret=%0d exp 2 1",
                     b12.stall_cycles, b12.retired);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        b8.instr = 8'h00;
        b8.zf = 1'b0;
        b8.mem_ready = 1'b0;
        b8.resume = 1'b0;
        b12.instr = 12'h000;
        b12.zf = 1'b0;
        b12.mem_ready = 1'b0;
        b12.resume = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jz();
        test_timeout();
        test_timeout_edge();
        test_halt();
        test_reset_mid_wait();
        test_jump12();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
